// File: rtl/axi4lite_cmd_manager_pkg.sv
// Shared constants for the AXI4-Lite command manager: response codes and FSM state encodings.
package axi4lite_cmd_manager_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WR    = 3'd1;
  localparam logic [2:0] ST_RD    = 3'd2;
  localparam logic [2:0] ST_RSP   = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

endpackage

// File: rtl/axi4lite_watchdog.sv
// Transaction watchdog: counts cycles while a transaction is in flight and flags expiry.
// A TIMEOUT_CYCLES of 0 disables expiry entirely.
module axi4lite_watchdog
  import axi4lite_cmd_manager_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic aclk,
  input  logic areset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CW-1:0] count;

  // Saturates at LAST so a long hang can never wrap back into a fresh window.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && run && (count == LAST);

endmodule

// File: rtl/axi4lite_cmd_manager.sv
// AXI4-Lite manager: turns a one-at-a-time command/response stream into single-beat
// AXI4-Lite reads and writes, with a watchdog that reports and drains hung subordinates.
module axi4lite_cmd_manager
  import axi4lite_cmd_manager_pkg::*;
#(
  parameter int         ADDR_WIDTH     = 32,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [2:0] AXPROT         = 3'b000
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic                  hung,
  output logic [ADDR_WIDTH-1:0] m_axi_lite_awaddr,
  output logic [2:0]            m_axi_lite_awprot,
  output logic                  m_axi_lite_awvalid,
  input  logic                  m_axi_lite_awready,
  output logic [31:0]           m_axi_lite_wdata,
  output logic [3:0]            m_axi_lite_wstrb,
  output logic                  m_axi_lite_wvalid,
  input  logic                  m_axi_lite_wready,
  input  logic [1:0]            m_axi_lite_bresp,
  input  logic                  m_axi_lite_bvalid,
  output logic                  m_axi_lite_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_lite_araddr,
  output logic [2:0]            m_axi_lite_arprot,
  output logic                  m_axi_lite_arvalid,
  input  logic                  m_axi_lite_arready,
  input  logic [31:0]           m_axi_lite_rdata,
  input  logic [1:0]            m_axi_lite_rresp,
  input  logic                  m_axi_lite_rvalid,
  output logic                  m_axi_lite_rready
);

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic                  aw_done;
  logic                  w_done;
  logic                  txn_open;
  logic                  timed_out;
  logic                  cmd_fire;
  logic                  aw_fire;
  logic                  w_fire;
  logic                  ar_fire;
  logic                  b_fire;
  logic                  r_fire;
  logic                  in_txn;
  logic                  wd_expired;

  assign m_axi_lite_awaddr = addr_q;
  assign m_axi_lite_araddr = addr_q;
  assign m_axi_lite_wdata  = wdata_q;
  assign m_axi_lite_wstrb  = wstrb_q;
  assign m_axi_lite_awprot = AXPROT;
  assign m_axi_lite_arprot = AXPROT;

  // B only counts once both AW and W were accepted on an earlier edge.
  assign cmd_fire = cmd_valid && cmd_ready;
  assign aw_fire  = m_axi_lite_awvalid && m_axi_lite_awready;
  assign w_fire   = m_axi_lite_wvalid && m_axi_lite_wready;
  assign ar_fire  = m_axi_lite_arvalid && m_axi_lite_arready;
  assign b_fire   = m_axi_lite_bready && m_axi_lite_bvalid && aw_done && w_done;
  assign r_fire   = m_axi_lite_rready && m_axi_lite_rvalid;
  assign in_txn   = (state == ST_WR) || (state == ST_RD);

  axi4lite_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .aclk   (aclk),
    .areset (areset),
    .clear  (cmd_fire),
    .run    (in_txn),
    .expired(wd_expired)
  );

  // Channel tracking runs in every non-idle state so a timed-out transaction keeps
  // its valids up and still completes its handshakes while RSP and DRAIN proceed.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state              <= ST_IDLE;
      cmd_ready          <= 1'b0;
      addr_q             <= '0;
      wdata_q            <= '0;
      wstrb_q            <= '0;
      aw_done            <= 1'b0;
      w_done             <= 1'b0;
      txn_open           <= 1'b0;
      timed_out          <= 1'b0;
      rsp_valid          <= 1'b0;
      rsp_rdata          <= '0;
      rsp_resp           <= RESP_OKAY;
      rsp_timeout        <= 1'b0;
      hung               <= 1'b0;
      m_axi_lite_awvalid <= 1'b0;
      m_axi_lite_wvalid  <= 1'b0;
      m_axi_lite_bready  <= 1'b0;
      m_axi_lite_arvalid <= 1'b0;
      m_axi_lite_rready  <= 1'b0;
    end else begin
      if (state != ST_IDLE) begin
        if (aw_fire) begin
          m_axi_lite_awvalid <= 1'b0;
          aw_done            <= 1'b1;
        end
        if (w_fire) begin
          m_axi_lite_wvalid <= 1'b0;
          w_done            <= 1'b1;
        end
        if (ar_fire) begin
          m_axi_lite_arvalid <= 1'b0;
          m_axi_lite_rready  <= 1'b1;
        end
        if (b_fire) begin
          m_axi_lite_bready <= 1'b0;
          txn_open          <= 1'b0;
        end
        if (r_fire) begin
          m_axi_lite_rready <= 1'b0;
          txn_open          <= 1'b0;
        end
      end

      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_fire) begin
            cmd_ready <= 1'b0;
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            txn_open  <= 1'b1;
            timed_out <= 1'b0;
            if (cmd_write) begin
              m_axi_lite_awvalid <= 1'b1;
              m_axi_lite_wvalid  <= 1'b1;
              m_axi_lite_bready  <= 1'b1;
              state              <= ST_WR;
            end else begin
              m_axi_lite_arvalid <= 1'b1;
              state              <= ST_RD;
            end
          end
        end

        ST_WR, ST_RD: begin
          if ((state == ST_WR) ? b_fire : r_fire) begin
            rsp_valid   <= 1'b1;
            rsp_resp    <= (state == ST_WR) ? m_axi_lite_bresp : m_axi_lite_rresp;
            rsp_rdata   <= (state == ST_WR) ? 32'h0 : m_axi_lite_rdata;
            rsp_timeout <= 1'b0;
            state       <= ST_RSP;
          end else if (wd_expired) begin
            rsp_valid   <= 1'b1;
            rsp_resp    <= RESP_SLVERR;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b1;
            hung        <= 1'b1;
            timed_out   <= 1'b1;
            state       <= ST_RSP;
          end
        end

        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (timed_out) begin
              state <= ST_DRAIN;
            end else begin
              state     <= ST_IDLE;
              cmd_ready <= 1'b1;
            end
          end
        end

        ST_DRAIN: begin
          if (!txn_open || b_fire || r_fire) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            timed_out <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_cmd_manager.sv
// Directed bench for axi4lite_cmd_manager against a small configurable AXI4-Lite subordinate
// holding a 128-word register file (0x000-0x1FC mapped, everything above returns SLVERR).
module tb_axi4lite_cmd_manager;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic        hung;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int vectors = 0;
  int miscompares = 0;

  always #5 aclk = ~aclk;

  axi4lite_cmd_manager #(
    .ADDR_WIDTH    (32),
    .TIMEOUT_CYCLES(16),
    .AXPROT        (3'b000)
  ) dut (
    .aclk              (aclk),
    .areset            (areset),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_write         (cmd_write),
    .cmd_addr          (cmd_addr),
    .cmd_wdata         (cmd_wdata),
    .cmd_wstrb         (cmd_wstrb),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_rdata         (rsp_rdata),
    .rsp_resp          (rsp_resp),
    .rsp_timeout       (rsp_timeout),
    .hung              (hung),
    .m_axi_lite_awaddr (awaddr),
    .m_axi_lite_awprot (awprot),
    .m_axi_lite_awvalid(awvalid),
    .m_axi_lite_awready(awready),
    .m_axi_lite_wdata  (wdata),
    .m_axi_lite_wstrb  (wstrb),
    .m_axi_lite_wvalid (wvalid),
    .m_axi_lite_wready (wready),
    .m_axi_lite_bresp  (bresp),
    .m_axi_lite_bvalid (bvalid),
    .m_axi_lite_bready (bready),
    .m_axi_lite_araddr (araddr),
    .m_axi_lite_arprot (arprot),
    .m_axi_lite_arvalid(arvalid),
    .m_axi_lite_arready(arready),
    .m_axi_lite_rdata  (rdata),
    .m_axi_lite_rresp  (rresp),
    .m_axi_lite_rvalid (rvalid),
    .m_axi_lite_rready (rready)
  );

  // Subordinate model: each ready rises after its valid has waited the configured cycles.
  int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_lat = 0, r_lat = 0;
  bit          b_hold = 1'b0;
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic        aw_got, w_got, ar_got;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;
  logic [31:0] mem [0:127];
  int          aw_beats = 0, w_beats = 0, b_beats = 0, rsp_count = 0, proto_errs = 0;

  assign awready = awvalid && !aw_got && (aw_cnt >= aw_wait);
  assign wready  = wvalid && !w_got && (w_cnt >= w_wait);
  assign arready = arvalid && !ar_got && (ar_cnt >= ar_wait);

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      bvalid <= 1'b0; bresp <= 2'b00;
      rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
      for (int i = 0; i < 128; i++) mem[i] <= '0;
      mem[64] <= 32'h3;
    end else begin
      if (awvalid && awready) begin
        aw_got <= 1'b1; s_awaddr <= awaddr; aw_cnt <= 0; aw_beats <= aw_beats + 1;
      end else if (awvalid) begin
        aw_cnt <= aw_cnt + 1;
      end
      if (wvalid && wready) begin
        w_got <= 1'b1; s_wdata <= wdata; s_wstrb <= wstrb; w_cnt <= 0; w_beats <= w_beats + 1;
      end else if (wvalid) begin
        w_cnt <= w_cnt + 1;
      end
      if (arvalid && arready) begin
        ar_got <= 1'b1; s_araddr <= araddr; ar_cnt <= 0;
      end else if (arvalid) begin
        ar_cnt <= ar_cnt + 1;
      end
      if (aw_got && w_got && !bvalid) begin
        if (!b_hold && b_cnt >= b_lat) begin
          bvalid <= 1'b1;
          bresp  <= (s_awaddr < 32'h200) ? 2'b00 : 2'b10;
          if (s_awaddr < 32'h200)
            for (int i = 0; i < 4; i++)
              if (s_wstrb[i]) mem[s_awaddr[8:2]][8*i +: 8] <= s_wdata[8*i +: 8];
        end else begin
          b_cnt <= b_cnt + 1;
        end
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0; b_beats <= b_beats + 1;
      end
      if (ar_got && !rvalid) begin
        if (r_cnt >= r_lat) begin
          rvalid <= 1'b1;
          rdata  <= (s_araddr < 32'h200) ? mem[s_araddr[8:2]] : 32'h0;
          rresp  <= (s_araddr < 32'h200) ? 2'b00 : 2'b10;
        end else begin
          r_cnt <= r_cnt + 1;
        end
      end
      if (rvalid && rready) begin
        rvalid <= 1'b0; ar_got <= 1'b0; r_cnt <= 0;
      end
    end
  end

  // Protocol monitor: a valid left waiting must stay high with an unchanged payload.
  logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0]  p_wstrb;

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      p_awv <= 1'b0; p_awr <= 1'b0; p_wv <= 1'b0; p_wr <= 1'b0; p_arv <= 1'b0; p_arr <= 1'b0;
      p_awaddr <= '0; p_wdata <= '0; p_araddr <= '0; p_wstrb <= '0;
    end else begin
      if ((p_awv && !p_awr && (!awvalid || awaddr != p_awaddr)) ||
          (p_wv && !p_wr && (!wvalid || wdata != p_wdata || wstrb != p_wstrb)) ||
          (p_arv && !p_arr && (!arvalid || araddr != p_araddr)))
        proto_errs <= proto_errs + 1;
      if (rsp_valid && rsp_ready) rsp_count <= rsp_count + 1;
      p_awv <= awvalid; p_awr <= awready; p_awaddr <= awaddr;
      p_wv <= wvalid; p_wr <= wready; p_wdata <= wdata; p_wstrb <= wstrb;
      p_arv <= arvalid; p_arr <= arready; p_araddr <= araddr;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Offers one command and returns at the falling edge after the accepting rising edge.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb);
    bit ok;
    ok = 1'b0;
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    for (int i = 0; i < 60; i++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge aclk);
    end
    if (ok) @(posedge aclk);
    @(negedge aclk);
    cmd_valid = 1'b0;
    checkOutput("cmd_accepted", 64'(ok), 64'd1);
  endtask

  task automatic waitRsp(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (rsp_valid) break;
      @(negedge aclk);
    end
    checkOutput("rsp_valid_seen", 64'(rsp_valid), 64'd1);
  endtask

  task automatic consumeRsp();
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
  endtask

  int base_b, base_rsp;

  initial begin
    areset = 1'b1;
    repeat (3) @(negedge aclk);
    checkOutput("reset_outputs", {cmd_ready, rsp_valid, awvalid, wvalid, arvalid, bready, rready, hung}, 8'h00);
    checkOutput("reset_rsp_payload", {rsp_rdata, rsp_resp, rsp_timeout}, 35'h0);
    areset = 1'b0;
    @(negedge aclk);
    checkOutput("ready_after_reset", 64'(cmd_ready), 64'd1);

    // Plain write to the divider register, then read it back.
    applyStimulus(1'b1, 32'h104, 32'h0000_0031, 4'hF);
    checkOutput("wr_valids_latency1", {awvalid, wvalid, arvalid, cmd_ready}, 4'b1100);
    checkOutput("wr_addr_data", {awaddr, wdata}, {32'h104, 32'h31});
    waitRsp(20);
    checkOutput("wr_rsp", {rsp_resp, rsp_timeout, rsp_rdata}, 35'h0);
    checkOutput("wr_beats", {aw_beats[7:0], w_beats[7:0], b_beats[7:0]}, 24'h010101);
    checkOutput("wr_sub_capture", {s_awaddr, s_wdata, 28'h0, s_wstrb}, {32'h104, 32'h31, 32'hF});
    consumeRsp();
    applyStimulus(1'b0, 32'h104, 32'h0, 4'h0);
    waitRsp(20);
    checkOutput("readback_104", {rsp_resp, rsp_rdata}, {2'b00, 32'h31});
    consumeRsp();

    // W accepted three cycles before AW.
    aw_wait = 3;
    base_b = b_beats; base_rsp = rsp_count;
    applyStimulus(1'b1, 32'h108, 32'hA5A5_0000, 4'h3);
    checkOutput("skew_both_valid", {awvalid, wvalid}, 2'b11);
    @(negedge aclk);
    checkOutput("skew_w_dropped", {awvalid, wvalid}, 2'b10);
    waitRsp(30);
    checkOutput("skew_rsp", {rsp_resp, rsp_timeout}, 3'b000);
    checkOutput("skew_capture", {s_awaddr, s_wdata, 28'h0, s_wstrb}, {32'h108, 32'hA5A5_0000, 32'h3});
    consumeRsp();
    checkOutput("skew_one_b_one_rsp", {b_beats - base_b, rsp_count - base_rsp}, {32'd1, 32'd1});
    aw_wait = 0;

    // Slow read of the trigger config register, response held under back-pressure.
    ar_wait = 2; r_lat = 5;
    applyStimulus(1'b0, 32'h100, 32'h0, 4'h0);
    checkOutput("rd_arvalid", {arvalid, awvalid, wvalid, araddr}, {3'b100, 32'h100});
    waitRsp(40);
    checkOutput("rd_rsp", {rsp_resp, rsp_timeout, rsp_rdata}, {3'b000, 32'h3});
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      checkOutput($sformatf("rd_hold_%0d", i), {rsp_valid, rsp_resp, rsp_rdata}, {1'b1, 2'b00, 32'h3});
    end
    consumeRsp();
    ar_wait = 0; r_lat = 0;

    // Unmapped read returns SLVERR from the subordinate, not from the watchdog.
    applyStimulus(1'b0, 32'h200, 32'h0, 4'h0);
    waitRsp(20);
    checkOutput("unmapped_rsp", {rsp_resp, rsp_timeout, hung, rsp_rdata}, {2'b10, 1'b0, 1'b0, 32'h0});
    consumeRsp();

    // Subordinate withholds B; watchdog answers after 16 cycles, late B is drained.
    b_hold = 1'b1;
    base_b = b_beats; base_rsp = rsp_count;
    applyStimulus(1'b1, 32'h10C, 32'h55, 4'hF);
    repeat (15) @(negedge aclk);
    checkOutput("wd_not_early", {rsp_valid, hung}, 2'b00);
    @(negedge aclk);
    checkOutput("wd_rsp", {rsp_valid, rsp_resp, rsp_timeout, hung, rsp_rdata}, {1'b1, 2'b10, 1'b1, 1'b1, 32'h0});
    consumeRsp();
    repeat (22) @(negedge aclk);
    checkOutput("drain_blocks_cmd", {cmd_ready, rsp_valid, bready}, 3'b001);
    b_hold = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (cmd_ready) break;
      @(negedge aclk);
    end
    checkOutput("drain_done_ready", {cmd_ready, rsp_valid, hung}, 3'b101);
    checkOutput("drain_counts", {b_beats - base_b, rsp_count - base_rsp}, {32'd1, 32'd1});

    // Reset asserted while AW is waiting.
    aw_wait = 1000;
    applyStimulus(1'b1, 32'h104, 32'h77, 4'hF);
    checkOutput("pre_reset_awvalid", 64'(awvalid), 64'd1);
    #2 areset = 1'b1;
    #1 checkOutput("async_reset_drop", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready, hung}, 8'h00);
    @(negedge aclk);
    areset = 1'b0;
    aw_wait = 0;
    @(negedge aclk);
    checkOutput("ready_after_release", 64'(cmd_ready), 64'd1);

    checkOutput("axi_payload_stable", 64'(proto_errs), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: observed no end of test, expected $finish before 100000");
    $fatal(1, "[TB] stopping");
  end

endmodule
